// File: rtl/osd_event_depacketization_fixedwidth_pkg.sv
// Shared DII definitions for the fixed-width event depacketizer: flit type,
// header field positions, event type codes and the parser state encoding.
package osd_event_depacketization_fixedwidth_pkg;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit_t;

  // Header flit 2 field positions, shared with the packetizer side.
  localparam int unsigned TYPE_MSB     = 15;
  localparam int unsigned TYPE_LSB     = 14;
  localparam int unsigned TYPE_SUB_MSB = 13;
  localparam int unsigned TYPE_SUB_LSB = 10;

  localparam logic [1:0] TYPE_PLAIN = 2'b00;
  localparam logic [1:0] TYPE_EVENT = 2'b10;

  localparam logic [3:0] TYPE_SUB_EVENT_LAST     = 4'h0;
  localparam logic [3:0] TYPE_SUB_EVENT_CONT     = 4'h1;
  localparam logic [3:0] TYPE_SUB_EVENT_OVERFLOW = 4'h5;

  typedef enum logic [2:0] {
    StDest,
    StSrc,
    StType,
    StPayload,
    StDiscard,
    StEmit
  } state_e;

  function automatic logic is_event_sub(input logic [3:0] sub);
    return (sub == TYPE_SUB_EVENT_LAST) || (sub == TYPE_SUB_EVENT_CONT) ||
           (sub == TYPE_SUB_EVENT_OVERFLOW);
  endfunction

  // Builds header flit 2 from its fields.
  function automatic logic [15:0] type_flit(input logic [1:0] typ, input logic [3:0] sub);
    logic [15:0] f;
    f = '0;
    f[TYPE_MSB:TYPE_LSB]         = typ;
    f[TYPE_SUB_MSB:TYPE_SUB_LSB] = sub;
    return f;
  endfunction

endpackage

// File: rtl/osd_event_depacketization_fixedwidth_if.sv
// Flit input and event output bundle of the event depacketizer.
interface osd_event_depacketization_fixedwidth_if #(
  parameter int unsigned DATA_WIDTH = 112
);
  import osd_event_depacketization_fixedwidth_pkg::*;

  dii_flit_t             debug_in;
  logic                  debug_in_ready;
  logic [DATA_WIDTH-1:0] event_data;
  logic                  event_overflow;
  logic [15:0]           event_src;
  logic                  event_valid;
  logic                  event_ready;

  modport master (
    output debug_in, event_ready,
    input  debug_in_ready, event_data, event_overflow, event_src, event_valid
  );

  modport slave (
    input  debug_in, event_ready,
    output debug_in_ready, event_data, event_overflow, event_src, event_valid
  );

endinterface

// File: rtl/osd_event_depacketization_fixedwidth.sv
// Reassembles DATA_WIDTH-bit trace events from one or more DII event packets
// and presents each one on a valid/ready handshake.
module osd_event_depacketization_fixedwidth
  import osd_event_depacketization_fixedwidth_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 112,
  parameter int unsigned MAX_PKT_LEN = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [15:0]                          id,
  osd_event_depacketization_fixedwidth_if.slave bus,
  output logic                                 protocol_error
);

  localparam int unsigned NW  = (DATA_WIDTH + 15) / 16;
  localparam int unsigned WIW = $clog2(NW + 1);
  localparam int unsigned PCW = $clog2(MAX_PKT_LEN - 2);

  localparam logic [WIW-1:0] NW_W     = WIW'(NW);
  localparam logic [WIW-1:0] LAST_IDX = WIW'(NW - 1);
  localparam logic [PCW-1:0] PAY_MAX  = PCW'(MAX_PKT_LEN - 3);

  state_e           state_q;
  logic [WIW-1:0]   word_idx_q;
  logic [PCW-1:0]   pay_cnt_q;
  logic [NW*16-1:0] data_q;
  logic [15:0]      src_q;
  logic [3:0]       sub_q;
  logic             ovf_q;
  logic             valid_q;
  logic             perr_q;

  logic        flit_last;
  logic [15:0] flit_data;
  logic [1:0]  fld_type;
  logic [3:0]  fld_sub;

  assign flit_last = bus.debug_in.last;
  assign flit_data = bus.debug_in.data;
  assign fld_type  = flit_data[TYPE_MSB:TYPE_LSB];
  assign fld_sub   = flit_data[TYPE_SUB_MSB:TYPE_SUB_LSB];

  // Parser FSM, slot counter and assembly register; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StDest;
      word_idx_q <= '0;
      pay_cnt_q  <= '0;
      data_q     <= '0;
      src_q      <= '0;
      sub_q      <= TYPE_SUB_EVENT_LAST;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      if (state_q == StEmit) begin
        if (bus.event_ready) begin
          state_q    <= StDest;
          valid_q    <= 1'b0;
          ovf_q      <= 1'b0;
          word_idx_q <= '0;
          data_q     <= '0;
        end
      end else if (bus.debug_in.valid) begin
        case (state_q)
          StDest: begin
            if (flit_last) begin
              perr_q <= 1'b1;
            end else if (flit_data == id) begin
              state_q <= StSrc;
            end else begin
              state_q <= StDiscard;
            end
          end
          StSrc: begin
            if (flit_last) begin
              perr_q  <= 1'b1;
              state_q <= StDest;
            end else if (word_idx_q != '0 && flit_data != src_q) begin
              // A continuation from another source cannot belong to this event.
              perr_q     <= 1'b1;
              word_idx_q <= '0;
              data_q     <= '0;
              state_q    <= StDiscard;
            end else begin
              src_q   <= flit_data;
              state_q <= StType;
            end
          end
          StType: begin
            sub_q     <= fld_sub;
            pay_cnt_q <= '0;
            if (flit_last) begin
              perr_q  <= 1'b1;
              state_q <= StDest;
            end else if (fld_type != TYPE_EVENT || !is_event_sub(fld_sub)) begin
              perr_q  <= 1'b1;
              state_q <= StDiscard;
            end else begin
              state_q <= StPayload;
              if (fld_sub == TYPE_SUB_EVENT_OVERFLOW && word_idx_q != '0) begin
                perr_q     <= 1'b1;
                word_idx_q <= '0;
                data_q     <= '0;
              end
            end
          end
          StPayload: begin
            if (word_idx_q == NW_W || pay_cnt_q == PAY_MAX) begin
              perr_q     <= 1'b1;
              word_idx_q <= '0;
              data_q     <= '0;
              state_q    <= flit_last ? StDest : StDiscard;
            end else begin
              for (int unsigned k = 0; k < NW; k++) begin
                if (word_idx_q == WIW'(k)) data_q[16*k +: 16] <= flit_data;
              end
              word_idx_q <= word_idx_q + 1'b1;
              pay_cnt_q  <= pay_cnt_q + 1'b1;
              if (flit_last) begin
                if (sub_q == TYPE_SUB_EVENT_LAST && word_idx_q == LAST_IDX) begin
                  state_q <= StEmit;
                  valid_q <= 1'b1;
                  ovf_q   <= 1'b0;
                end else if (sub_q == TYPE_SUB_EVENT_CONT && word_idx_q < LAST_IDX) begin
                  state_q <= StDest;
                end else if (sub_q == TYPE_SUB_EVENT_OVERFLOW && pay_cnt_q == '0) begin
                  state_q <= StEmit;
                  valid_q <= 1'b1;
                  ovf_q   <= 1'b1;
                end else begin
                  perr_q     <= 1'b1;
                  word_idx_q <= '0;
                  data_q     <= '0;
                  state_q    <= StDest;
                end
              end
            end
          end
          StDiscard: begin
            if (flit_last) state_q <= StDest;
          end
          default: state_q <= StDest;
        endcase
      end
    end
  end

  assign bus.debug_in_ready = (state_q != StEmit);
  assign bus.event_data     = data_q[DATA_WIDTH-1:0];
  assign bus.event_overflow = ovf_q;
  assign bus.event_src      = src_q;
  assign bus.event_valid    = valid_q;
  assign protocol_error     = perr_q;

endmodule

// File: tb/tb_osd_event_depacketization_fixedwidth.sv
// Directed bench: a 32-bit instance (index 0) and a default 112-bit instance
// (index 1) share clock, reset and id; events are scoreboarded.
module tb_osd_event_depacketization_fixedwidth;
  import osd_event_depacketization_fixedwidth_pkg::*;

  typedef struct packed {
    logic         dut;
    logic [111:0] data;
    logic [15:0]  src;
    logic         ovf;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] id  = 16'h0005;
  logic        perr_s, perr_b;

  always #5 clk = ~clk;

  osd_event_depacketization_fixedwidth_if #(.DATA_WIDTH(32))  bus_s ();
  osd_event_depacketization_fixedwidth_if #(.DATA_WIDTH(112)) bus_b ();

  osd_event_depacketization_fixedwidth #(.DATA_WIDTH(32), .MAX_PKT_LEN(8)) dut_s (
    .clk(clk), .rst(rst), .id(id), .bus(bus_s), .protocol_error(perr_s)
  );

  osd_event_depacketization_fixedwidth #(.DATA_WIDTH(112), .MAX_PKT_LEN(8)) dut_b (
    .clk(clk), .rst(rst), .id(id), .bus(bus_b), .protocol_error(perr_b)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_ev[2];
  int   n_perr[2];
  ev_t  got_q[$];
  ev_t  exp_q[$];
  int   hs_s[$];
  logic [15:0] pl[8];
  int   npl;

  always @(posedge clk) cyc <= cyc + 1;

  // Records completed handshakes and error pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_s.event_valid && bus_s.event_ready) begin
        got_q.push_back('{dut: 1'b0, data: 112'(bus_s.event_data), src: bus_s.event_src,
                          ovf: bus_s.event_overflow});
        hs_s.push_back(cyc);
        n_ev[0]++;
      end
      if (bus_b.event_valid && bus_b.event_ready) begin
        got_q.push_back('{dut: 1'b1, data: bus_b.event_data, src: bus_b.event_src,
                          ovf: bus_b.event_overflow});
        n_ev[1]++;
      end
      if (perr_s) n_perr[0]++;
      if (perr_b) n_perr[1]++;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit big, input logic [111:0] d, input logic [15:0] s,
                          input logic o);
    exp_q.push_back('{dut: big, data: d, src: s, ovf: o});
  endtask

  task automatic send_flit(input bit big, input logic last, input logic [15:0] d);
    int w;
    logic rdy;
    w = 0;
    if (big) bus_b.debug_in = '{valid: 1'b1, last: last, data: d};
    else     bus_s.debug_in = '{valid: 1'b1, last: last, data: d};
    rdy = big ? bus_b.debug_in_ready : bus_s.debug_in_ready;
    while (rdy !== 1'b1 && w < 40) begin
      tick();
      w++;
      rdy = big ? bus_b.debug_in_ready : bus_s.debug_in_ready;
    end
    if (w >= 40) check("flit_accept_timeout", rdy, 1'b1);
    tick();
  endtask

  task automatic idle(input bit big);
    if (big) bus_b.debug_in.valid = 1'b0;
    else     bus_s.debug_in.valid = 1'b0;
  endtask

  task automatic send_pkt(input bit big, input logic [15:0] dest, input logic [15:0] src,
                          input logic [1:0] typ, input logic [3:0] sub);
    send_flit(big, 1'b0, dest);
    send_flit(big, 1'b0, src);
    send_flit(big, npl == 0, type_flit(typ, sub));
    for (int i = 0; i < npl; i++) send_flit(big, i == npl - 1, pl[i]);
    idle(big);
  endtask

  // Waits (bounded) for a handshake count, then scores every recorded event.
  task automatic wait_ev(input bit big, input int target);
    int w;
    ev_t g, e;
    w = 0;
    while (n_ev[big] < target && w < 60) begin
      tick();
      w++;
    end
    check("event_count", n_ev[big], target);
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      check("event_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("event_dut", g.dut, e.dut);
        check("event_data", g.data, e.data);
        check("event_src", g.src, e.src);
        check("event_overflow", g.ovf, e.ovf);
      end
    end
  endtask

  task automatic check_zero(input bit big);
    if (big) begin
      check("rst_valid_b", bus_b.event_valid, 1'b0);
      check("rst_data_b", bus_b.event_data, '0);
      check("rst_src_b", bus_b.event_src, '0);
      check("rst_ovf_b", bus_b.event_overflow, 1'b0);
      check("rst_perr_b", perr_b, 1'b0);
      check("rst_ready_b", bus_b.debug_in_ready, 1'b1);
    end else begin
      check("rst_valid_s", bus_s.event_valid, 1'b0);
      check("rst_data_s", bus_s.event_data, '0);
      check("rst_src_s", bus_s.event_src, '0);
      check("rst_ovf_s", bus_s.event_overflow, 1'b0);
      check("rst_perr_s", perr_s, 1'b0);
      check("rst_ready_s", bus_s.debug_in_ready, 1'b1);
    end
  endtask

  task automatic set_pl5(input logic [15:0] base);
    npl = 5;
    for (int i = 0; i < 5; i++) pl[i] = base + 16'(i);
  endtask

  initial begin
    int pe0, ev0, base;
    bus_s.debug_in    = '0;
    bus_b.debug_in    = '0;
    bus_s.event_ready = 1'b0;
    bus_b.event_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_zero(1'b0);
    check_zero(1'b1);

    // Single-packet 32-bit event with consumer back-pressure.
    npl = 2; pl[0] = 16'hBEEF; pl[1] = 16'hDEAD;
    push_exp(1'b0, 112'hDEAD_BEEF, 16'h0012, 1'b0);
    send_pkt(1'b0, 16'h0005, 16'h0012, TYPE_EVENT, TYPE_SUB_EVENT_LAST);
    check("latency_valid", bus_s.event_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", bus_s.event_valid, 1'b1);
      check("hold_ready", bus_s.debug_in_ready, 1'b0);
      check("hold_data", bus_s.event_data, 32'hDEAD_BEEF);
      check("hold_src", bus_s.event_src, 16'h0012);
    end
    bus_s.event_ready = 1'b1;
    tick();
    check("after_hs_valid", bus_s.event_valid, 1'b0);
    check("after_hs_ready", bus_s.debug_in_ready, 1'b1);
    wait_ev(1'b0, 1);

    // Split event over CONT + LAST.
    set_pl5(16'h0001);
    send_pkt(1'b1, 16'h0005, 16'h0012, TYPE_EVENT, TYPE_SUB_EVENT_CONT);
    repeat (3) tick();
    check("no_event_after_cont", n_ev[1], 0);
    push_exp(1'b1, 112'h0007_0006_0005_0004_0003_0002_0001, 16'h0012, 1'b0);
    npl = 2; pl[0] = 16'h0006; pl[1] = 16'h0007;
    send_pkt(1'b1, 16'h0005, 16'h0012, TYPE_EVENT, TYPE_SUB_EVENT_LAST);
    wait_ev(1'b1, 1);

    // Overflow record.
    push_exp(1'b1, 112'h3, 16'h0012, 1'b1);
    npl = 1; pl[0] = 16'h0003;
    send_pkt(1'b1, 16'h0005, 16'h0012, TYPE_EVENT, TYPE_SUB_EVENT_OVERFLOW);
    wait_ev(1'b1, 2);

    // Overflow after a partial assembly: error, then the overflow event alone.
    pe0 = n_perr[1];
    npl = 2; pl[0] = 16'h000A; pl[1] = 16'h000B;
    send_pkt(1'b1, 16'h0005, 16'h0012, TYPE_EVENT, TYPE_SUB_EVENT_CONT);
    push_exp(1'b1, 112'h3, 16'h0012, 1'b1);
    npl = 1; pl[0] = 16'h0003;
    send_pkt(1'b1, 16'h0005, 16'h0012, TYPE_EVENT, TYPE_SUB_EVENT_OVERFLOW);
    wait_ev(1'b1, 3);
    check("ovf_partial_perr", n_perr[1], pe0 + 1);

    // Foreign destination: silently consumed.
    pe0 = n_perr[1]; ev0 = n_ev[1];
    set_pl5(16'h0100);
    send_pkt(1'b1, 16'h0009, 16'h0012, TYPE_EVENT, TYPE_SUB_EVENT_LAST);
    repeat (3) tick();
    check("dest_filter_perr", n_perr[1], pe0);
    check("dest_filter_ev", n_ev[1], ev0);

    // Non-event type.
    npl = 2; pl[0] = 16'h1111; pl[1] = 16'h2222;
    send_pkt(1'b1, 16'h0005, 16'h0012, TYPE_PLAIN, TYPE_SUB_EVENT_LAST);
    repeat (3) tick();
    check("plain_perr", n_perr[1], pe0 + 1);
    check("plain_ev", n_ev[1], ev0);

    // LAST with only 6 of 7 flits.
    set_pl5(16'h0200);
    send_pkt(1'b1, 16'h0005, 16'h0012, TYPE_EVENT, TYPE_SUB_EVENT_CONT);
    npl = 1; pl[0] = 16'h0205;
    send_pkt(1'b1, 16'h0005, 16'h0012, TYPE_EVENT, TYPE_SUB_EVENT_LAST);
    repeat (3) tick();
    check("short_perr", n_perr[1], pe0 + 2);
    check("short_ev", n_ev[1], ev0);

    // Continuation from a different source.
    npl = 3; pl[0] = 16'h0301; pl[1] = 16'h0302; pl[2] = 16'h0303;
    send_pkt(1'b1, 16'h0005, 16'h0012, TYPE_EVENT, TYPE_SUB_EVENT_CONT);
    npl = 4; pl[0] = 16'h0304; pl[1] = 16'h0305; pl[2] = 16'h0306; pl[3] = 16'h0307;
    send_pkt(1'b1, 16'h0005, 16'h0013, TYPE_EVENT, TYPE_SUB_EVENT_LAST);
    repeat (3) tick();
    check("src_mismatch_perr", n_perr[1], pe0 + 3);
    check("src_mismatch_ev", n_ev[1], ev0);

    // Assembly was cleared: a fresh split event is clean.
    set_pl5(16'h0401);
    send_pkt(1'b1, 16'h0005, 16'h0021, TYPE_EVENT, TYPE_SUB_EVENT_CONT);
    npl = 2; pl[0] = 16'h0406; pl[1] = 16'h0407;
    push_exp(1'b1, 112'h0407_0406_0405_0404_0403_0402_0401, 16'h0021, 1'b0);
    send_pkt(1'b1, 16'h0005, 16'h0021, TYPE_EVENT, TYPE_SUB_EVENT_LAST);
    wait_ev(1'b1, ev0 + 1);
    check("clean_after_errors_perr", n_perr[1], pe0 + 3);

    // Reset with the 32-bit instance in EMIT and the wide one mid-packet.
    bus_s.event_ready = 1'b0;
    npl = 2; pl[0] = 16'h5555; pl[1] = 16'h6666;
    send_pkt(1'b0, 16'h0005, 16'h0044, TYPE_EVENT, TYPE_SUB_EVENT_LAST);
    check("pre_rst_valid_s", bus_s.event_valid, 1'b1);
    send_flit(1'b1, 1'b0, 16'h0005);
    send_flit(1'b1, 1'b0, 16'h0033);
    send_flit(1'b1, 1'b0, type_flit(TYPE_EVENT, TYPE_SUB_EVENT_CONT));
    send_flit(1'b1, 1'b0, 16'h7777);
    send_flit(1'b1, 1'b0, 16'h8888);
    idle(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero(1'b0);
    check_zero(1'b1);
    bus_s.event_ready = 1'b1;
    ev0 = n_ev[1];
    set_pl5(16'h0501);
    send_pkt(1'b1, 16'h0005, 16'h0033, TYPE_EVENT, TYPE_SUB_EVENT_CONT);
    npl = 2; pl[0] = 16'h0506; pl[1] = 16'h0507;
    push_exp(1'b1, 112'h0507_0506_0505_0504_0503_0502_0501, 16'h0033, 1'b0);
    send_pkt(1'b1, 16'h0005, 16'h0033, TYPE_EVENT, TYPE_SUB_EVENT_LAST);
    wait_ev(1'b1, ev0 + 1);

    // Ten back-to-back single-packet events: 5 flits + 1 EMIT cycle each.
    ev0 = n_ev[0];
    npl = 2;
    for (int k = 0; k < 10; k++) begin
      pl[0] = 16'h1000 + 16'(k);
      pl[1] = 16'h2000 + 16'(k);
      push_exp(1'b0, {80'h0, pl[1], pl[0]}, 16'h0040 + 16'(k), 1'b0);
      send_pkt(1'b0, 16'h0005, 16'h0040 + 16'(k), TYPE_EVENT, TYPE_SUB_EVENT_LAST);
    end
    wait_ev(1'b0, ev0 + 10);
    base = hs_s.size() - 10;
    if (base >= 0) begin
      for (int i = 1; i < 10; i++) check("b2b_spacing", hs_s[base + i] - hs_s[base + i - 1], 6);
    end

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    check("no_stray_events", got_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/osd_event_depacketization_fixedwidth.md
Name: osd_event_depacketization_fixedwidth

Overview:
- Receive side of fixed-width event packetization: consumes DII event packets from the debug interconnect and reassembles each DATA_WIDTH-bit trace event, including events split across several packets.
- Sits in host-side or in-fabric trace consumers, for example a trace sink or a loopback checker for trace modules.
- Presents one event per valid/ready handshake, together with an overflow flag and the source module ID.

Parameters:
- DATA_WIDTH, 112, event payload width in bits (32 timestamp + 16 id + 64 value). NW = ceil(DATA_WIDTH/16) payload flits per event.
- MAX_PKT_LEN, 8, maximum flits per packet including the 3 header flits. Up to MAX_PKT_LEN-3 payload flits per packet; must be >= 4.

Ports:
- clk  in  1  clock; the block has one clock.
- rst  in  1  reset, synchronous, active-high.
- id  in  16  own DI address; packets with dest != id are discarded.
- debug_in  in  dii_flit  incoming flit (valid, last, data[15:0]).
- debug_in_ready  out  1  flit accepted when debug_in.valid && debug_in_ready.
- event_data  out  DATA_WIDTH  reassembled event. Flit k of the event fills bits [16k+15:16k]; the top flit is truncated to DATA_WIDTH.
- event_overflow  out  1  event is an overflow record; event_data[15:0] = lost-event count, other bits 0.
- event_src  out  16  src field of the packet(s) carrying the event.
- event_valid  out  1  event available.
- event_ready  in  1  consumer accepts the event.
- protocol_error  out  1  single-cycle pulse on each malformed packet.

Behaviour:
- Header format:
  - Flit 0 = dest.
  - Flit 1 = src.
  - Flit 2: [15:14] TYPE, [13:10] TYPE_SUB.
  - Only TYPE_EVENT is accepted. Sub-types: EVENT_LAST (event completes in this packet), EVENT_CONT (more packets follow), EVENT_OVERFLOW (exactly one payload flit carrying the count).
- FSM states: DEST, SRC, TYPE, PAYLOAD, DISCARD, EMIT. All transitions occur on accepted flits, except EMIT.
- debug_in_ready is 1 in every state except EMIT, where it is 0.
- DEST:
  - dest == id -> SRC.
  - dest != id -> DISCARD, with no error.
  - last = 1 -> error, stay in DEST.
- SRC: latch src.
  - A continuation packet (assembly in progress) whose src differs from the latched src -> error, clear the assembly, then DISCARD.
  - last = 1 -> error, back to DEST.
- TYPE: latch sub-type.
  - TYPE != EVENT or unknown sub-type -> error, DISCARD.
  - OVERFLOW while an assembly is partial -> error, drop the partial assembly, then continue with the overflow packet.
  - last = 1 -> error, DEST.
  - Otherwise -> PAYLOAD.
- PAYLOAD:
  - Write the flit into word slot word_idx, then increment word_idx.
  - A flit arriving with word_idx == NW, or a per-packet payload count exceeding MAX_PKT_LEN-3 -> error, clear, DISCARD (or DEST if last).
  - On the last flit:
    - LAST with word_idx+1 == NW -> EMIT.
    - CONT with word_idx+1 < NW -> DEST, keeping the assembly.
    - OVERFLOW with exactly 1 payload flit -> EMIT with event_overflow = 1.
    - Any other combination -> error, clear word_idx, DEST.
- DISCARD: accept and drop flits until last, then DEST.
- EMIT:
  - event_valid = 1; event_data, event_overflow and event_src are held stable.
  - On event_ready -> clear word_idx and the data register, go to DEST.
- Latency: event_valid rises the cycle after the final flit is accepted. The back-to-back rate is one event per (packet flits + 1) cycles.
- protocol_error pulses in the cycle after the offending flit is accepted.
- Reset:
  - Reset values: state DEST, word_idx 0, event_data 0, event_src 0, event_overflow 0, event_valid 0, protocol_error 0.
  - debug_in_ready = 1 from the first cycle after reset.
  - Reset mid-packet or mid-EMIT drops everything; the remaining flits of an interrupted packet are then parsed as a new header. Upstream reset is shared.
- The debug_in.data value is ignored when valid = 0.

Decomposition:
- dii_package (shared):
  - TYPE_EVENT = 2'b10, TYPE_SUB_EVENT_LAST = 4'h0, TYPE_SUB_EVENT_CONT = 4'h1, TYPE_SUB_EVENT_OVERFLOW = 4'h5.
  - Header field bit positions, so the packetizer and this block share one definition.
- No sub-module. Single FSM plus the word_idx counter and data register.

Test Plan:
- Single-packet event: DATA_WIDTH = 32, MAX_PKT_LEN = 8.
  - Stimulus: packet dest = id = 0x0005, src = 0x0012, LAST, payload 0xBEEF, 0xDEAD.
  - Response: event_valid one cycle after last; event_data = 0xDEADBEEF, src 0x0012, overflow 0.
  - Hold event_ready = 0 for 5 cycles: debug_in_ready = 0 and outputs stable throughout.
- Split event: defaults (NW = 7).
  - Stimulus: CONT packet with payload 0x0001..0x0005, then LAST packet with 0x0006, 0x0007.
  - Response: one event with data = 0x0007_0006_0005_0004_0003_0002_0001; no event after the first packet.
- Overflow: overflow packet with payload 0x0003 -> event_overflow = 1, event_data = 3.
  - An overflow packet arriving after a partial CONT packet -> protocol_error pulse, then the overflow event.
- Filtering and errors:
  - dest 0x0009 != id -> whole packet consumed, no event, no error.
  - TYPE = PLAIN -> one error pulse, discard.
  - LAST packet with 6 of 7 flits -> error, no event.
  - Continuation packet with a different src -> error, no event.
- Reset mid-packet: assert rst after 2 payload flits.
  - Response: all outputs 0 next cycle.
  - A following valid packet then reassembles correctly.
- Back-to-back throughput: 10 consecutive single-packet events with event_ready = 1.
  - Response: 10 events in order; each costs packet flits + 1 cycles.
